// File: rtl/lstm_seq_controller.sv
// lstm_seq_controller
// Steps an LSTM layer and its output perceptron through fixed-length
// sequences. Each timestep takes one input vector, runs the layer, runs the
// perceptron and hands the scalar result downstream. The layer's recurrent
// state is cleared between sequences. A watchdog abandons the sequence when
// the datapath stalls.
module lstm_seq_controller #(
  parameter int INPUT_SZ = 2,
  parameter int QN       = 6,
  parameter int QM       = 11,
  parameter int SEQ_LEN  = 8,
  parameter int TIMEOUT  = 1024,
  parameter int BITWIDTH = QN + QM + 1,
  parameter int STEP_W   = $clog2(SEQ_LEN)
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         s_valid,
  output logic                         s_ready,
  input  logic [BITWIDTH*INPUT_SZ-1:0] s_data,
  output logic [BITWIDTH*INPUT_SZ-1:0] layer_input,
  output logic                         layer_newSample,
  output logic                         layer_reset,
  input  logic                         layer_dataReady,
  output logic                         perc_reset,
  input  logic                         perc_dataReady,
  input  logic [BITWIDTH-1:0]          perc_output,
  output logic                         m_valid,
  input  logic                         m_ready,
  output logic [BITWIDTH-1:0]          m_data,
  output logic                         m_last,
  output logic [STEP_W-1:0]            step,
  output logic                         error
);

  // The watchdog counts 0 .. TIMEOUT-1, so TIMEOUT-1 must fit.
  localparam int WD_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [WD_W-1:0]   WD_LAST   = WD_W'(TIMEOUT - 1);
  localparam logic [STEP_W-1:0] STEP_LAST = STEP_W'(SEQ_LEN - 1);

  typedef enum logic [2:0] {
    S_LRST    = 3'd0,
    S_WAIT_IN = 3'd1,
    S_ISSUE   = 3'd2,
    S_WAIT_L  = 3'd3,
    S_GAP     = 3'd4,
    S_RUN_P   = 3'd5,
    S_OUT     = 3'd6
  } state_t;

  state_t                         state_q;
  logic                           lrst_cnt_q;
  logic [STEP_W-1:0]              step_q;
  logic [WD_W-1:0]                wd_q;
  logic                           error_q;
  logic [BITWIDTH*INPUT_SZ-1:0]   layer_input_q;
  logic [BITWIDTH-1:0]            m_data_q;
  logic                           m_last_q;
  logic                           layer_rdy_prev_q;
  logic                           perc_rdy_prev_q;

  // Only a fresh 0->1 transition counts as a result; a level left high from
  // the previous timestep must not be mistaken for a new answer.
  logic layer_rise;
  logic perc_rise;
  assign layer_rise = layer_dataReady & ~layer_rdy_prev_q;
  assign perc_rise  = perc_dataReady  & ~perc_rdy_prev_q;

  // Previous-value samples for edge detection, updated every cycle.
  always_ff @(posedge clock) begin
    layer_rdy_prev_q <= layer_dataReady;
    perc_rdy_prev_q  <= perc_dataReady;
  end

  // Sequencing FSM with step counter, watchdog and result capture.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q       <= S_LRST;
      lrst_cnt_q    <= 1'b0;
      step_q        <= '0;
      wd_q          <= '0;
      error_q       <= 1'b0;
      layer_input_q <= '0;
      m_data_q      <= '0;
      m_last_q      <= 1'b0;
    end else begin
      case (state_q)
        // Two-cycle layer reset; the counter is left at 0 for the next entry.
        S_LRST: begin
          if (lrst_cnt_q) begin
            lrst_cnt_q <= 1'b0;
            step_q     <= '0;
            state_q    <= S_WAIT_IN;
          end else begin
            lrst_cnt_q <= 1'b1;
          end
        end
        S_WAIT_IN: begin
          if (s_valid) begin
            layer_input_q <= s_data;
            state_q       <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          wd_q    <= '0;
          state_q <= S_WAIT_L;
        end
        // The awaited edge is tested first so it wins over a watchdog expiry.
        S_WAIT_L: begin
          if (layer_rise) begin
            state_q <= S_GAP;
          end else if (wd_q == WD_LAST) begin
            error_q <= 1'b1;
            state_q <= S_LRST;
          end else begin
            wd_q <= wd_q + WD_W'(1);
          end
        end
        S_GAP: begin
          wd_q    <= '0;
          state_q <= S_RUN_P;
        end
        S_RUN_P: begin
          if (perc_rise) begin
            m_data_q <= perc_output;
            m_last_q <= (step_q == STEP_LAST);
            state_q  <= S_OUT;
          end else if (wd_q == WD_LAST) begin
            error_q <= 1'b1;
            state_q <= S_LRST;
          end else begin
            wd_q <= wd_q + WD_W'(1);
          end
        end
        S_OUT: begin
          if (m_ready) begin
            if (m_last_q) begin
              state_q <= S_LRST;
            end else begin
              step_q  <= step_q + STEP_W'(1);
              state_q <= S_WAIT_IN;
            end
          end
        end
        default: begin
          state_q    <= S_LRST;
          lrst_cnt_q <= 1'b0;
        end
      endcase
    end
  end

  // Control outputs decode the registered state; the two resets also follow
  // the external reset so the datapath is held from the very first cycle.
  assign s_ready         = (state_q == S_WAIT_IN);
  assign layer_newSample = (state_q == S_ISSUE);
  assign m_valid         = (state_q == S_OUT);
  assign layer_reset     = reset | (state_q == S_LRST);
  assign perc_reset      = reset | (state_q != S_RUN_P);
  assign layer_input     = layer_input_q;
  assign m_data          = m_data_q;
  assign m_last          = m_last_q;
  assign step            = step_q;
  assign error           = error_q;

endmodule

// File: tb/tb_lstm_seq_controller.sv
// Bench for lstm_seq_controller: behavioural layer and perceptron models plus
// a scoreboard of expected perceptron results per timestep.
module tb_lstm_seq_controller;

  localparam int BW  = 18;
  localparam int INS = 2;
  localparam int DW  = BW * INS;
  localparam int SEQ = 8;
  localparam int SW  = 3;
  localparam int TO  = 16;

  typedef struct packed {
    logic [BW-1:0] data;
    logic          last;
  } exp_t;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          s_valid = 1'b0;
  logic          s_ready;
  logic [DW-1:0] s_data = '0;
  logic [DW-1:0] layer_input;
  logic          layer_newSample;
  logic          layer_reset;
  logic          layer_dataReady;
  logic          perc_reset;
  logic          perc_dataReady = 1'b0;
  logic [BW-1:0] perc_output = '0;
  logic          m_valid;
  logic          m_ready = 1'b0;
  logic [BW-1:0] m_data;
  logic          m_last;
  logic [SW-1:0] step;
  logic          error;

  int   errors = 0;
  int   checks = 0;
  exp_t sb[$];

  // layer model controls
  logic mdl_l = 1'b0;
  logic man_l = 1'b0;
  logic layer_manual = 1'b0;
  logic layer_never = 1'b0;
  int   lcnt = 0;
  int   pcnt = 0;

  assign layer_dataReady = layer_manual ? man_l : mdl_l;

  lstm_seq_controller #(
    .INPUT_SZ(INS), .QN(6), .QM(11), .SEQ_LEN(SEQ), .TIMEOUT(TO)
  ) dut (
    .clock(clock), .reset(reset),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .layer_input(layer_input), .layer_newSample(layer_newSample),
    .layer_reset(layer_reset), .layer_dataReady(layer_dataReady),
    .perc_reset(perc_reset), .perc_dataReady(perc_dataReady),
    .perc_output(perc_output),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_last(m_last),
    .step(step), .error(error)
  );

  always #5 clock = ~clock;

  // Layer: dataReady drops on newSample and rises 5 cycles later.
  always @(negedge clock) begin
    if (layer_newSample === 1'b1) begin
      mdl_l = 1'b0;
      lcnt  = 5;
    end else if (lcnt > 0) begin
      lcnt = lcnt - 1;
      if (lcnt == 0 && !layer_never) mdl_l = 1'b1;
    end
  end

  // Perceptron: answers step*3 three cycles after perc_reset falls.
  always @(negedge clock) begin
    if (perc_reset !== 1'b0) begin
      perc_dataReady = 1'b0;
      pcnt = 0;
    end else if (pcnt < 3) begin
      pcnt = pcnt + 1;
      if (pcnt == 3) begin
        perc_dataReady = 1'b1;
        perc_output    = BW'(int'(step) * 3);
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL global_limit: still running at %0t, required finish", $time);
    $fatal(1, "time limit reached");
  end

  // One sequence; bp/stale/to/abort select the step receiving special treatment.
  task automatic run_seq(input int bp_step, input int stale_step, input int to_step, input int abort_step);
    logic [DW-1:0] vec;
    exp_t e;
    int n;
    for (int i = 0; i < SEQ; i++) begin
      n = 0;
      while (s_ready !== 1'b1 && n < 100) begin @(negedge clock); n++; end
      checks++;
      if (s_ready !== 1'b1) begin
        errors++;
        $display("FAIL s_ready_wait step=%0d: s_ready=%b, required 1 within 100 cycles", i, s_ready);
        return;
      end
      vec = {BW'($urandom), BW'($urandom)};
      s_data  = vec;
      s_valid = 1'b1;
      layer_manual = (i == stale_step);
      man_l        = 1'b1;
      layer_never  = (i == to_step);
      if (i != to_step && i != abort_step) begin
        e.data = BW'(i * 3);
        e.last = (i == SEQ - 1);
        sb.push_back(e);
      end
      @(negedge clock);
      s_valid = 1'b0;
      checks++;
      if (layer_newSample !== 1'b1 || s_ready !== 1'b0 || layer_input !== vec) begin
        errors++;
        $display("FAIL issue step=%0d: newSample=%b s_ready=%b layer_input=%h, required 1 0 %h",
                 i, layer_newSample, s_ready, layer_input, vec);
      end

      if (i == to_step) begin
        for (int k = 0; k < TO; k++) begin
          @(negedge clock);
          checks++;
          if (error !== 1'b0 || m_valid !== 1'b0) begin
            errors++;
            $display("FAIL wd_early cycle=%0d: error=%b m_valid=%b, required 0 0", k, error, m_valid);
          end
        end
        @(negedge clock);
        checks++;
        if (error !== 1'b1 || layer_reset !== 1'b1 || m_valid !== 1'b0) begin
          errors++;
          $display("FAIL wd_fire: error=%b layer_reset=%b m_valid=%b, required 1 1 0", error, layer_reset, m_valid);
        end
        @(negedge clock);
        checks++;
        if (layer_reset !== 1'b1 || s_ready !== 1'b0) begin
          errors++;
          $display("FAIL wd_lrst: layer_reset=%b s_ready=%b, required 1 0", layer_reset, s_ready);
        end
        @(negedge clock);
        checks++;
        if (s_ready !== 1'b1 || layer_reset !== 1'b0 || step !== '0) begin
          errors++;
          $display("FAIL wd_restart: s_ready=%b layer_reset=%b step=%0d, required 1 0 0", s_ready, layer_reset, step);
        end
        layer_never = 1'b0;
        return;
      end

      if (i == abort_step) begin
        n = 0;
        while (perc_reset !== 1'b0 && n < 50) begin @(negedge clock); n++; end
        checks++;
        if (perc_reset !== 1'b0) begin
          errors++;
          $display("FAIL abort_wait: perc_reset=%b, required 0 within 50 cycles", perc_reset);
        end
        reset = 1'b1;
        @(negedge clock);
        checks++;
        if ({perc_reset, layer_reset, m_valid, s_ready, m_last, error} !== 6'b110000 ||
            step !== '0 || m_data !== '0 || layer_input !== '0) begin
          errors++;
          $display("FAIL abort_reset: pr=%b lr=%b mv=%b sr=%b ml=%b err=%b step=%0d m_data=%h li=%h, required 1 1 0 0 0 0 0 0 0",
                   perc_reset, layer_reset, m_valid, s_ready, m_last, error, step, m_data, layer_input);
        end
        reset = 1'b0;
        @(negedge clock);
        checks++;
        if (layer_reset !== 1'b1 || s_ready !== 1'b0) begin
          errors++;
          $display("FAIL abort_lrst: layer_reset=%b s_ready=%b, required 1 0", layer_reset, s_ready);
        end
        @(negedge clock);
        checks++;
        if (s_ready !== 1'b1 || layer_reset !== 1'b0) begin
          errors++;
          $display("FAIL abort_restart: s_ready=%b layer_reset=%b, required 1 0", s_ready, layer_reset);
        end
        return;
      end

      if (i == stale_step) begin
        @(negedge clock);
        checks++;
        if (perc_reset !== 1'b1 || layer_newSample !== 1'b0) begin
          errors++;
          $display("FAIL stale_w1: perc_reset=%b newSample=%b, required 1 0", perc_reset, layer_newSample);
        end
        @(negedge clock);
        checks++;
        if (perc_reset !== 1'b1) begin
          errors++;
          $display("FAIL stale_w2: perc_reset=%b, required 1", perc_reset);
        end
        man_l = 1'b0;
        @(negedge clock);
        checks++;
        if (perc_reset !== 1'b1) begin
          errors++;
          $display("FAIL stale_low: perc_reset=%b, required 1", perc_reset);
        end
        man_l = 1'b1;
        @(negedge clock);
        checks++;
        if (perc_reset !== 1'b1) begin
          errors++;
          $display("FAIL stale_gap: perc_reset=%b, required 1", perc_reset);
        end
        @(negedge clock);
        checks++;
        if (perc_reset !== 1'b0) begin
          errors++;
          $display("FAIL stale_run: perc_reset=%b, required 0", perc_reset);
        end
        n = 5;
      end else begin
        @(negedge clock);
        n = 1;
        checks++;
        if (layer_newSample !== 1'b0) begin
          errors++;
          $display("FAIL newsample_pulse step=%0d: newSample=%b, required 0", i, layer_newSample);
        end
      end

      while (m_valid !== 1'b1 && n < 200) begin @(negedge clock); n++; end
      checks++;
      if (m_valid !== 1'b1) begin
        errors++;
        $display("FAIL m_valid_wait step=%0d: m_valid=%b, required 1 within 200 cycles", i, m_valid);
        return;
      end
      if (i != stale_step) begin
        checks++;
        if (n != 10) begin
          errors++;
          $display("FAIL latency step=%0d: %0d cycles from newSample to m_valid, required 10", i, n);
        end
      end
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL sb_empty step=%0d: queue size 0, required an expected entry", i);
        return;
      end
      e = sb.pop_front();
      checks++;
      if (m_data !== e.data || m_last !== e.last || step !== SW'(i)) begin
        errors++;
        $display("FAIL result step=%0d: m_data=%0d m_last=%b step=%0d, required %0d %b %0d",
                 i, m_data, m_last, step, e.data, e.last, i);
      end

      if (i == bp_step) begin
        for (int k = 0; k < 10; k++) begin
          @(negedge clock);
          checks++;
          if (m_valid !== 1'b1 || m_data !== e.data || m_last !== e.last || s_ready !== 1'b0) begin
            errors++;
            $display("FAIL bp_hold cycle=%0d: m_valid=%b m_data=%0d m_last=%b s_ready=%b, required 1 %0d %b 0",
                     k, m_valid, m_data, m_last, s_ready, e.data, e.last);
          end
        end
      end

      m_ready = 1'b1;
      @(negedge clock);
      m_ready = 1'b0;
      layer_manual = 1'b0;
      if (!e.last) begin
        checks++;
        if (m_valid !== 1'b0 || step !== SW'(i + 1)) begin
          errors++;
          $display("FAIL step_adv step=%0d: m_valid=%b step=%0d, required 0 %0d", i, m_valid, step, i + 1);
        end
      end else begin
        checks++;
        if (m_valid !== 1'b0 || layer_reset !== 1'b1 || s_ready !== 1'b0) begin
          errors++;
          $display("FAIL seq_end_lrst1: m_valid=%b layer_reset=%b s_ready=%b, required 0 1 0", m_valid, layer_reset, s_ready);
        end
        @(negedge clock);
        checks++;
        if (layer_reset !== 1'b1 || s_ready !== 1'b0) begin
          errors++;
          $display("FAIL seq_end_lrst2: layer_reset=%b s_ready=%b, required 1 0", layer_reset, s_ready);
        end
        @(negedge clock);
        checks++;
        if (s_ready !== 1'b1 || layer_reset !== 1'b0 || step !== '0) begin
          errors++;
          $display("FAIL seq_restart: s_ready=%b layer_reset=%b step=%0d, required 1 0 0", s_ready, layer_reset, step);
        end
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clock);
      checks++;
      if ({layer_reset, perc_reset, s_ready, layer_newSample, m_valid, m_last, error} !== 7'b1100000 ||
          m_data !== '0 || layer_input !== '0 || step !== '0) begin
        errors++;
        $display("FAIL reset_values cycle=%0d: lr=%b pr=%b sr=%b ns=%b mv=%b ml=%b err=%b m_data=%h li=%h step=%0d, required 1 1 0 0 0 0 0 0 0 0",
                 k, layer_reset, perc_reset, s_ready, layer_newSample, m_valid, m_last, error, m_data, layer_input, step);
      end
    end
    reset = 1'b0;
    #1;
    checks++;
    if (layer_reset !== 1'b1 || perc_reset !== 1'b1 || s_ready !== 1'b0) begin
      errors++;
      $display("FAIL startup_lrst1: lr=%b pr=%b sr=%b, required 1 1 0", layer_reset, perc_reset, s_ready);
    end
    @(negedge clock);
    checks++;
    if (layer_reset !== 1'b1 || s_ready !== 1'b0) begin
      errors++;
      $display("FAIL startup_lrst2: lr=%b sr=%b, required 1 0", layer_reset, s_ready);
    end
    @(negedge clock);
    checks++;
    if (layer_reset !== 1'b0 || s_ready !== 1'b1) begin
      errors++;
      $display("FAIL startup_ready: lr=%b sr=%b, required 0 1", layer_reset, s_ready);
    end
  endtask

  task automatic test_full_sequence();
    run_seq(-1, -1, -1, -1);
  endtask

  task automatic test_backpressure();
    run_seq(2, -1, -1, -1);
  endtask

  task automatic test_stale_ready();
    run_seq(-1, 1, -1, -1);
  endtask

  task automatic test_timeout();
    run_seq(-1, -1, 3, -1);
    run_seq(-1, -1, -1, -1);
    checks++;
    if (error !== 1'b1) begin
      errors++;
      $display("FAIL error_sticky: error=%b, required 1", error);
    end
  endtask

  task automatic test_reset_in_run_p();
    run_seq(-1, -1, -1, 2);
    run_seq(-1, -1, -1, -1);
    checks++;
    if (error !== 1'b0 || sb.size() != 0) begin
      errors++;
      $display("FAIL final_state: error=%b pending=%0d, required 0 0", error, sb.size());
    end
  endtask

  initial begin
    test_reset();
    test_full_sequence();
    test_backpressure();
    test_stale_ready();
    test_timeout();
    test_reset_in_run_p();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/lstm_seq_controller.md
# lstm_seq_controller

Sequencing controller between a streaming sample source and the LSTM `network` layer plus its `array_prod` output perceptron. It runs sequences of SEQ_LEN timesteps. For each timestep it:
- accepts one input vector through a valid/ready handshake,
- pulses `newSample` into the layer and waits for the layer result,
- enables the perceptron and captures its scalar output,
- presents that output downstream through a valid/ready handshake.

At each sequence boundary it clears the layer's recurrent state with a layer reset, and a watchdog catches a stalled datapath.

## Interface
- INPUT_SZ, 2, input vector elements
- QN, 6, integer bits (Q format)
- QM, 11, fractional bits
- SEQ_LEN, 8, timesteps per sequence (≥2)
- TIMEOUT, 1024, max cycles waiting on any datapath ready
- BITWIDTH, QN+QM+1, derived element width
- STEP_W, $clog2(SEQ_LEN), derived step-counter width
---
- clock  in  1  single clock; all logic on posedge
- reset  in  1  synchronous, active-high
- s_valid  in  1  input sample valid
- s_ready  out  1  controller can accept a sample
- s_data  in  BITWIDTH*INPUT_SZ  input vector, element i at [i*BITWIDTH +: BITWIDTH]
- layer_input  out  BITWIDTH*INPUT_SZ  registered vector to layer `inputVec`
- layer_newSample  out  1  one-cycle start pulse to layer
- layer_reset  out  1  layer reset
- layer_dataReady  in  1  layer result valid (level)
- perc_reset  out  1  perceptron reset; low only while it computes
- perc_dataReady  in  1  perceptron result valid (level)
- perc_output  in  BITWIDTH  perceptron result
- m_valid  out  1  result valid
- m_ready  in  1  downstream accepts
- m_data  out  BITWIDTH  captured perceptron result
- m_last  out  1  m_data belongs to timestep SEQ_LEN-1
- step  out  STEP_W  current timestep index
- error  out  1  sticky watchdog flag

## Operation
- FSM states:
  - LRST: 2 cycles; layer_reset=1; step←0 on exit. Then → WAIT_IN.
  - WAIT_IN: s_ready=1. When s_valid: layer_input←s_data, → ISSUE.
  - ISSUE: 1 cycle; layer_newSample=1. Then → WAIT_L.
  - WAIT_L: on a layer_dataReady rising edge → GAP.
  - GAP: 1 cycle. Then → RUN_P.
  - RUN_P: perc_reset=0. On a perc_dataReady rising edge: m_data←perc_output, m_last←(step==SEQ_LEN-1), → OUT.
  - OUT: m_valid=1. When m_ready: if m_last → LRST, else step←step+1 and → WAIT_IN.
- Rising edge means the input is 1 this cycle and its registered previous value is 0. Previous-value registers update every cycle, in all states.
- A ready line still high from the previous timestep is therefore never taken as a new result.
- layer_reset = reset OR state==LRST.
- perc_reset = reset OR state!=RUN_P.
- Watchdog:
  - The counter clears on entry to WAIT_L and on entry to RUN_P, and increments each cycle spent in those states.
  - When the count reaches TIMEOUT-1 without the awaited edge: error←1, sequence abandoned, no m_valid, → LRST (step restarts at 0).
  - error clears only on reset.
- layer_input and m_data hold their values until the next capture.
- Arithmetic: none on data; widths pass through unmodified.

## Timing
- On reset, the FSM enters LRST and all outputs take these values:
  - layer_reset=1, perc_reset=1
  - s_ready=0, layer_newSample=0
  - m_valid=0, m_last=0, m_data=0, layer_input=0
  - step=0, error=0
- Startup: the first s_ready=1 occurs 2 cycles after reset deasserts (LRST runs 2 cycles).
- Input accepted at cycle t:
  - layer_newSample=1 at t+1 only.
  - Edge detection active from t+2.
- Layer rising edge sampled at cycle d: perc_reset=0 from d+2.
- Perceptron rising edge sampled at cycle p: m_valid=1 at p+1, perc_reset=1 at p+1.
- Handshakes:
  - m_valid, m_data and m_last stay stable while m_ready=0.
  - s_ready is 0 in every state except WAIT_IN.
- Reset asserted in any state (mid-computation included) aborts the sequence and behaves as power-on reset.
- A rising edge arriving while the FSM is not waiting for it is ignored.
- Simultaneous timeout expiry and awaited edge: the edge wins, with no error.

## Test plan
1. Hold reset for 3 cycles, then release. Required: all outputs at their reset values during reset, then layer_reset=1 for exactly 2 cycles, then s_ready=1.
2. Full sequence: SEQ_LEN=8, layer model raises dataReady 5 cycles after newSample, perceptron model raises dataReady 3 cycles after perc_reset falls and returns perc_output=step*3. Required: 8 results 0,3,…,21; m_last=1 only on the result of 21; a 2-cycle layer_reset before the next s_ready.
3. Backpressure: hold m_ready=0 for 10 cycles on step 2. Required: m_data=6 stable and s_ready=0 throughout; step advances to 3 one cycle after m_ready=1.
4. Stale ready: hold layer_dataReady=1 across an ISSUE, drop it for 1 cycle, then raise it. Required: the FSM leaves WAIT_L only on that re-raise.
5. Timeout: TIMEOUT=16, layer never answers. Required: error=1 sixteen cycles after entering WAIT_L, no m_valid, layer_reset for 2 cycles, step=0, error stays 1 through a following good sequence.
6. Assert reset during RUN_P. Required: perc_reset=1 and layer_reset=1 next cycle, step=0, error=0, and a following sequence completes normally.
